// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Optional feature macro: ID_EX_LOAD_USE_DETECT_EN. When it is defined, a load in EX
// whose destination is read by the valid instruction in ID raises load_use_stall.
// The same condition also loads a single bubble into EX. When the macro is undefined,
// load_use_stall is tied low and only flush inserts bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              CLK,
  input  logic              ID_EX_RST,
  input  logic              RegWrite_D,
  input  logic              MemRead_D,
  input  logic              MemWrite_D,
  input  logic              MemtoReg_D,
  input  logic              Branch_D,
  input  logic              Jump_D,
  input  logic              ALU_SrcA_D,
  input  logic              ALU_SrcB_D,
  input  logic              Jal_WB_D,
  input  logic              RegDst_D,
  input  logic [3:0]        ALUOp_D,
  input  logic [5:0]        opcode_D,
  input  logic [DATA_W-1:0] rs_data_D,
  input  logic [DATA_W-1:0] rt_data_D,
  input  logic [DATA_W-1:0] imm_D,
  input  logic [DATA_W-1:0] pc4_D,
  input  logic [RA_W-1:0]   rs_D,
  input  logic [RA_W-1:0]   rt_D,
  input  logic [RA_W-1:0]   rd_D,
  input  logic [RA_W-1:0]   shamt_D,
  input  logic              valid_D,
  input  logic              stall_in,
  input  logic              flush,
  output logic              RegWrite_E,
  output logic              MemRead_E,
  output logic              MemWrite_E,
  output logic              MemtoReg_E,
  output logic              Branch_E,
  output logic              Jump_E,
  output logic              ALU_SrcA_E,
  output logic              ALU_SrcB_E,
  output logic              Jal_WB_E,
  output logic [3:0]        ALUOp_E,
  output logic [5:0]        opcode_E,
  output logic [DATA_W-1:0] rs_data_E,
  output logic [DATA_W-1:0] rt_data_E,
  output logic [DATA_W-1:0] imm_E,
  output logic [DATA_W-1:0] pc4_E,
  output logic [RA_W-1:0]   rs_E,
  output logic [RA_W-1:0]   rt_E,
  output logic [RA_W-1:0]   rd_E,
  output logic [RA_W-1:0]   shamt_E,
  output logic              valid_E,
  output logic [RA_W-1:0]   dst_E,
  output logic              load_use_stall
);

  localparam logic [RA_W-1:0] LINK_REG = RA_W'(31);

  logic [RA_W-1:0] dstNext;
  logic            loadUseHit;
  logic            clearE;

  // Destination register: link register for jal, else rd or rt per RegDst.
  always_comb begin
    dstNext = rt_D;
    if (Jal_WB_D) begin
      dstNext = LINK_REG;
    end else if (RegDst_D) begin
      dstNext = rd_D;
    end
  end

`ifdef ID_EX_LOAD_USE_DETECT_EN
  // Load in EX feeding a valid ID consumer; register 0 never creates a hazard.
  always_comb begin
    loadUseHit = 1'b0;
    if (!ID_EX_RST && valid_E && MemRead_E && valid_D && (dst_E != '0) &&
        ((dst_E == rs_D) || (dst_E == rt_D))) begin
      loadUseHit = 1'b1;
    end
  end
`else
  assign loadUseHit = 1'b0;
`endif

  assign load_use_stall = loadUseHit;

  // Reset, flush and load-use bubble all leave EX holding an all-zero slot.
  assign clearE = ID_EX_RST | flush | loadUseHit;

  // Pipeline register: clear beats hold, and hold beats a normal load.
  always_ff @(posedge CLK) begin
    if (clearE) begin
      RegWrite_E <= 1'b0;
      MemRead_E  <= 1'b0;
      MemWrite_E <= 1'b0;
      MemtoReg_E <= 1'b0;
      Branch_E   <= 1'b0;
      Jump_E     <= 1'b0;
      ALU_SrcA_E <= 1'b0;
      ALU_SrcB_E <= 1'b0;
      Jal_WB_E   <= 1'b0;
      ALUOp_E    <= '0;
      opcode_E   <= '0;
      rs_data_E  <= '0;
      rt_data_E  <= '0;
      imm_E      <= '0;
      pc4_E      <= '0;
      rs_E       <= '0;
      rt_E       <= '0;
      rd_E       <= '0;
      shamt_E    <= '0;
      valid_E    <= 1'b0;
      dst_E      <= '0;
    end else if (!stall_in) begin
      RegWrite_E <= RegWrite_D;
      MemRead_E  <= MemRead_D;
      MemWrite_E <= MemWrite_D;
      MemtoReg_E <= MemtoReg_D;
      Branch_E   <= Branch_D;
      Jump_E     <= Jump_D;
      ALU_SrcA_E <= ALU_SrcA_D;
      ALU_SrcB_E <= ALU_SrcB_D;
      Jal_WB_E   <= Jal_WB_D;
      ALUOp_E    <= ALUOp_D;
      opcode_E   <= opcode_D;
      rs_data_E  <= rs_data_D;
      rt_data_E  <= rt_data_D;
      imm_E      <= imm_D;
      pc4_E      <= pc4_D;
      rs_E       <= rs_D;
      rt_E       <= rt_D;
      rd_E       <= rd_D;
      shamt_E    <= shamt_D;
      valid_E    <= valid_D;
      dst_E      <= dstNext;
    end
  end

endmodule
